// File: rtl/kyber_pkg.sv
// Shared constants, FSM state type and the Compress_q(x,1) bit rule for the
// Kyber message compress path.
package kyber_pkg;

  localparam int unsigned KYBER_Q  = 3329;
  localparam int unsigned COMP1_LO = 833;
  localparam int unsigned COMP1_HI = 2496;
  localparam int unsigned N_COEF   = 256;
  localparam int unsigned N_PAIRS  = N_COEF / 2;
  localparam int unsigned N_BYTES  = N_COEF / 8;
  localparam int unsigned COEF_W   = 16;
  localparam int unsigned IDX_W    = 8;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned CNT_W    = $clog2(N_BYTES);
  localparam int unsigned PAIR_W   = $clog2(N_PAIRS);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INPUT  = 3'd1,
    ST_FLUSH  = 3'd2,
    ST_OUTPUT = 3'd3,
    ST_DONE   = 3'd4
  } comp1_state_e;

  // Fold [Q,2Q) down once, then test the window that rounds to 1.
  function automatic logic comp1_bit(input logic [COEF_W-1:0] x);
    logic [COEF_W-1:0] xr;
    xr = (x >= COEF_W'(KYBER_Q)) ? x - COEF_W'(KYBER_Q) : x;
    return (xr >= COEF_W'(COMP1_LO)) && (xr <= COEF_W'(COMP1_HI));
  endfunction

endpackage

// File: rtl/compress1_cal.sv
// One-coefficient Compress_q(x,1): registers the message bit one cycle after x.
module compress1_cal
  import kyber_pkg::*;
(
  input  logic              clk,
  input  logic              set,
  input  logic [COEF_W-1:0] x,
  output logic              b
);

  logic b_d;
  logic b_q;

  assign b_d = comp1_bit(x);

  // Consumers qualify this bit with their own valid, so no reset is needed.
  always_ff @(posedge clk) begin
    if (set) b_q <= b_d;
  end

  assign b = b_q;

endmodule

// File: rtl/compress1.sv
// Kyber message compress: collects 256 coefficients as pairs, packs one bit
// each into a 32-byte buffer and streams the bytes out with a handshake.
module compress1
  import kyber_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              set,
  input  logic              readin,
  input  logic              full_in,
  input  logic [COEF_W-1:0] comp_din_1,
  input  logic [COEF_W-1:0] comp_din_2,
  input  logic [IDX_W-1:0]  in_index,
  input  logic              readout,
  output logic [BYTE_W-1:0] comp_dout,
  output logic [IDX_W-1:0]  out_index,
  output logic              readin_ok,
  output logic              readout_ok,
  output logic              done
);

  comp1_state_e      state_q;
  logic              flush_cnt_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              readin_ok_q;
  logic              readout_ok_q;
  logic              done_q;
  logic [BYTE_W-1:0] dout_q;
  logic [IDX_W-1:0]  out_index_q;

  logic              wr_vld_q;
  logic [PAIR_W-1:0] wr_pair_q;
  logic              bit_1;
  logic              bit_2;
  logic              capture_c;

  logic [BYTE_W-1:0] buf_q [N_BYTES];

  // Out-of-range pair indices are dropped rather than aliased.
  assign capture_c = set & readin & readin_ok_q & ~in_index[IDX_W-1];
  assign cnt_d     = cnt_q + CNT_W'(1);

  compress1_cal u_cal_1 (
    .clk (clk),
    .set (set),
    .x   (comp_din_1),
    .b   (bit_1)
  );

  compress1_cal u_cal_2 (
    .clk (clk),
    .set (set),
    .x   (comp_din_2),
    .b   (bit_2)
  );

  // Pair index tracks the cal register so both land in the buffer together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_vld_q  <= 1'b0;
      wr_pair_q <= '0;
    end else if (set) begin
      wr_vld_q  <= capture_c;
      wr_pair_q <= in_index[PAIR_W-1:0];
    end
  end

  // Bit-addressable message buffer; pair p owns bits 2*(p&3)+{0,1} of byte p>>2.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(N_BYTES); i++) buf_q[i] <= '0;
    end else if (set) begin
      if (state_q == ST_IDLE) begin
        for (int i = 0; i < int'(N_BYTES); i++) buf_q[i] <= '0;
      end else if (wr_vld_q) begin
        buf_q[wr_pair_q[PAIR_W-1:2]][{wr_pair_q[1:0], 1'b0}] <= bit_1;
        buf_q[wr_pair_q[PAIR_W-1:2]][{wr_pair_q[1:0], 1'b1}] <= bit_2;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      flush_cnt_q  <= 1'b0;
      cnt_q        <= '0;
      readin_ok_q  <= 1'b0;
      readout_ok_q <= 1'b0;
      done_q       <= 1'b0;
      dout_q       <= '0;
      out_index_q  <= '0;
    end else if (set) begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          state_q     <= ST_INPUT;
          readin_ok_q <= 1'b1;
        end
        ST_INPUT: begin
          if (full_in) begin
            state_q     <= ST_FLUSH;
            readin_ok_q <= 1'b0;
            flush_cnt_q <= 1'b0;
          end
        end
        // Two cycles let the last captured pair reach the buffer.
        ST_FLUSH: begin
          if (flush_cnt_q) begin
            state_q      <= ST_OUTPUT;
            readout_ok_q <= 1'b1;
            cnt_q        <= '0;
            dout_q       <= buf_q[0];
            out_index_q  <= '0;
          end else begin
            flush_cnt_q <= 1'b1;
          end
        end
        ST_OUTPUT: begin
          if (readout) begin
            if (cnt_q == CNT_W'(N_BYTES - 1)) begin
              state_q      <= ST_DONE;
              readout_ok_q <= 1'b0;
              done_q       <= 1'b1;
              dout_q       <= '0;
              out_index_q  <= '0;
            end else begin
              cnt_q       <= cnt_d;
              dout_q      <= buf_q[cnt_d];
              out_index_q <= IDX_W'(cnt_d);
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q      <= ST_IDLE;
          readin_ok_q  <= 1'b0;
          readout_ok_q <= 1'b0;
        end
      endcase
    end
  end

  assign comp_dout  = dout_q;
  assign out_index  = out_index_q;
  assign readin_ok  = readin_ok_q;
  assign readout_ok = readout_ok_q;
  assign done       = done_q;

endmodule

// File: tb/tb_compress1.sv
// Directed bench for compress1: thresholds, packing, stalls, set-hold and
// mid-stream reset, each checked against bench-computed message bytes.
module tb_compress1;

  localparam int Q = 3329;

  logic        clk;
  logic        reset;
  logic        set;
  logic        readin;
  logic        full_in;
  logic [15:0] din1;
  logic [15:0] din2;
  logic [7:0]  in_index;
  logic        readout;
  logic [7:0]  comp_dout;
  logic [7:0]  out_index;
  logic        readin_ok;
  logic        readout_ok;
  logic        done;

  int          vec_cnt;
  int          err_cnt;
  int          coef [256];
  logic [7:0]  exp_b [32];
  logic [7:0]  msg [32];

  compress1 dut (
    .clk        (clk),
    .reset      (reset),
    .set        (set),
    .readin     (readin),
    .full_in    (full_in),
    .comp_din_1 (din1),
    .comp_din_2 (din2),
    .in_index   (in_index),
    .readout    (readout),
    .comp_dout  (comp_dout),
    .out_index  (out_index),
    .readin_ok  (readin_ok),
    .readout_ok (readout_ok),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no end want end");
    $fatal(1, "watchdog");
  end

  // round(2x/Q) mod 2, written as an integer rounding divide.
  function automatic logic model_bit(input int x);
    int xm;
    xm = x % Q;
    return (((4 * xm + Q) / (2 * Q)) % 2) == 1;
  endfunction

  task automatic idle_inputs();
    set      = 1'b1;
    readin   = 1'b0;
    full_in  = 1'b0;
    readout  = 1'b0;
    din1     = '0;
    din2     = '0;
    in_index = '0;
  endtask

  task automatic build_expected();
    for (int b = 0; b < 32; b++) exp_b[b] = 8'h00;
    for (int i = 0; i < 256; i++) exp_b[i / 8][i % 8] = model_bit(coef[i]);
  endtask

  task automatic wait_readin_ok();
    for (int n = 0; n < 20 && readin_ok !== 1'b1; n++) @(negedge clk);
    vec_cnt++;
    if (readin_ok !== 1'b1) begin
      err_cnt++;
      $display("FAIL readin_ok_wait: got %b want 1", readin_ok);
    end
  endtask

  // Drives one pair for exactly one rising edge; called at a negedge.
  task automatic send_pair(input int p, input int c1, input int c2, input bit last);
    set      = 1'b1;
    readin   = 1'b1;
    in_index = 8'(p);
    din1     = 16'(c1);
    din2     = 16'(c2);
    full_in  = last;
    @(negedge clk);
  endtask

  task automatic send_all(input bit rev, input bit gap);
    int p;
    wait_readin_ok();
    for (int k = 0; k < 128; k++) begin
      p = rev ? 127 - k : k;
      if (gap && k == 64) begin
        set      = 1'b0;
        readin   = 1'b1;
        full_in  = 1'b1;
        in_index = 8'd0;
        din1     = model_bit(coef[0]) ? 16'd0 : 16'd1665;
        din2     = model_bit(coef[1]) ? 16'd0 : 16'd1665;
        for (int g = 0; g < 4; g++) begin
          @(negedge clk);
          vec_cnt++;
          if (readin_ok !== 1'b1 || readout_ok !== 1'b0) begin
            err_cnt++;
            $display("FAIL set_hold_state: got readin_ok=%b readout_ok=%b want 1 0",
                     readin_ok, readout_ok);
          end
        end
      end
      send_pair(p, coef[2 * p], coef[2 * p + 1], k == 127);
    end
    readin  = 1'b0;
    full_in = 1'b0;
  endtask

  task automatic read_all(input string tag, input int stall_at, input bit early);
    if (early) readout = 1'b1;
    for (int n = 0; n < 20 && readout_ok !== 1'b1; n++) @(negedge clk);
    for (int b = 0; b < 32; b++) begin
      vec_cnt++;
      if (comp_dout !== exp_b[b] || out_index !== 8'(b) || readout_ok !== 1'b1) begin
        err_cnt++;
        $display("FAIL %s byte%0d: got dout=%h idx=%0d ok=%b want dout=%h idx=%0d ok=1",
                 tag, b, comp_dout, out_index, readout_ok, exp_b[b], b);
      end
      if (b == stall_at) begin
        readout = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          vec_cnt++;
          if (comp_dout !== exp_b[b] || out_index !== 8'(b)) begin
            err_cnt++;
            $display("FAIL %s stall%0d: got dout=%h idx=%0d want dout=%h idx=%0d",
                     tag, s, comp_dout, out_index, exp_b[b], b);
          end
        end
      end
      readout = 1'b1;
      @(negedge clk);
    end
    readout = 1'b0;
    vec_cnt++;
    if (done !== 1'b1 || readout_ok !== 1'b0) begin
      err_cnt++;
      $display("FAIL %s done_pulse: got done=%b ok=%b want 1 0", tag, done, readout_ok);
    end
    @(negedge clk);
    vec_cnt++;
    if (done !== 1'b0 || readin_ok !== 1'b0) begin
      err_cnt++;
      $display("FAIL %s done_end: got done=%b readin_ok=%b want 0 0", tag, done, readin_ok);
    end
  endtask

  task automatic make_random_msg();
    int noise;
    for (int b = 0; b < 32; b++) msg[b] = 8'($urandom_range(255));
    for (int i = 0; i < 256; i++) begin
      noise   = int'($urandom_range(800)) - 400;
      coef[i] = (msg[i / 8][i % 8] ? 1665 : 0) + noise + Q;
      coef[i] = coef[i] % Q;
      if ($urandom_range(1) == 1) coef[i] = coef[i] + Q;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    vec_cnt++;
    if (readin_ok !== 1'b0 || readout_ok !== 1'b0 || done !== 1'b0 ||
        comp_dout !== 8'h00 || out_index !== 8'h00) begin
      err_cnt++;
      $display("FAIL reset_outputs: got %b %b %b %h %h want 0 0 0 00 00",
               readin_ok, readout_ok, done, comp_dout, out_index);
    end
    reset = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if (readin_ok !== 1'b1) begin
      err_cnt++;
      $display("FAIL reset_to_input: got readin_ok=%b want 1", readin_ok);
    end
  endtask

  // Threshold edges, [Q,2Q) folding, duplicate index, dropped index, late readin.
  task automatic test_thresholds();
    wait_readin_ok();
    send_pair(0, 0, 832, 1'b0);
    send_pair(1, 833, 2496, 1'b0);
    send_pair(2, 2497, 3328, 1'b0);
    send_pair(3, 1665, 1665, 1'b0);
    send_pair(130, 1665, 1665, 1'b0);
    send_pair(3, 0, 0, 1'b0);
    send_pair(4, 4162, 6657, 1'b1);
    readin   = 1'b1;
    in_index = 8'd1;
    din1     = 16'd0;
    din2     = 16'd0;
    full_in  = 1'b0;
    vec_cnt++;
    if (readin_ok !== 1'b0) begin
      err_cnt++;
      $display("FAIL flush_readin_ok: got %b want 0", readin_ok);
    end
    for (int b = 0; b < 32; b++) exp_b[b] = 8'h00;
    exp_b[0] = 8'h0C;
    exp_b[1] = 8'h01;
    read_all("thresh", -1, 1'b0);
    readin = 1'b0;
  endtask

  task automatic test_all_half();
    for (int i = 0; i < 256; i++) coef[i] = 1665;
    for (int b = 0; b < 32; b++) exp_b[b] = 8'hFF;
    send_all(1'b0, 1'b0);
    read_all("half", -1, 1'b1);
  endtask

  task automatic test_random_msg();
    make_random_msg();
    for (int b = 0; b < 32; b++) exp_b[b] = msg[b];
    send_all(1'b0, 1'b0);
    read_all("rand", -1, 1'b0);
  endtask

  task automatic test_set_hold();
    for (int b = 0; b < 32; b++) exp_b[b] = msg[b];
    send_all(1'b0, 1'b1);
    read_all("sethold", -1, 1'b0);
  endtask

  task automatic test_reverse_stall();
    for (int i = 0; i < 256; i++) coef[i] = int'($urandom_range(2 * Q - 1));
    build_expected();
    send_all(1'b1, 1'b0);
    read_all("revstall", 10, 1'b0);
  endtask

  task automatic test_reset_mid();
    make_random_msg();
    send_all(1'b0, 1'b0);
    for (int n = 0; n < 20 && readout_ok !== 1'b1; n++) @(negedge clk);
    readout = 1'b1;
    for (int b = 0; b < 10; b++) @(negedge clk);
    vec_cnt++;
    if (out_index !== 8'd10 || comp_dout !== msg[10]) begin
      err_cnt++;
      $display("FAIL midreset_pre: got idx=%0d dout=%h want idx=10 dout=%h",
               out_index, comp_dout, msg[10]);
    end
    reset   = 1'b0;
    readout = 1'b0;
    #1;
    vec_cnt++;
    if (readout_ok !== 1'b0 || comp_dout !== 8'h00 || out_index !== 8'h00 || done !== 1'b0) begin
      err_cnt++;
      $display("FAIL midreset_outputs: got ok=%b dout=%h idx=%0d done=%b want 0 00 0 0",
               readout_ok, comp_dout, out_index, done);
    end
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    wait_readin_ok();
    send_pair(0, 1665, 1665, 1'b0);
    send_pair(127, 1665, 0, 1'b1);
    readin  = 1'b0;
    full_in = 1'b0;
    for (int b = 0; b < 32; b++) exp_b[b] = 8'h00;
    exp_b[0]  = 8'h03;
    exp_b[31] = 8'h40;
    read_all("postreset", -1, 1'b0);
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    test_reset();
    test_thresholds();
    test_all_half();
    test_random_msg();
    test_set_hold();
    test_reverse_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
